// File: rtl/atb_funnel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : atb_funnel_arbiter
//  Purpose  : Packet-aware round-robin funnel. It shares one ATB master port
//             among NUM_SRC trace sources. A grant is held until the source
//             sends ATLAST or until HOLD_MAX beats have been sent. Sources can
//             be masked individually, and an ATB flush (AFVALID/AFREADY) is
//             sequenced across all enabled sources. The output goes through
//             a single registered slice.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_ni        clock, asynchronous active-low reset
//    cfg_enable_i         per-source enable; a disabled source is never granted
//    s_atvalid_i/id/data/last, s_atready_o
//                         packed per-source ATB slave side, src0 in the LSBs
//    s_afvalid_o, s_afready_i
//                         per-source flush request / flush complete
//    m_atvalid_o/id/data/last, m_atready_i
//                         registered ATB master side
//    flush_req_i          level flush request, sampled only while idle
//    flush_done_o         one-cycle pulse when the flush has completed
//    cur_src_o            index of the current (or most recent) grant
// ============================================================================
module atb_funnel_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ATID_WIDTH = 7,
    parameter int HOLD_MAX   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_SRC-1:0]            cfg_enable_i,
    input  logic [NUM_SRC-1:0]            s_atvalid_i,
    input  logic [NUM_SRC*ATID_WIDTH-1:0] s_atid_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_atdata_i,
    input  logic [NUM_SRC-1:0]            s_atlast_i,
    output logic [NUM_SRC-1:0]            s_atready_o,
    output logic [NUM_SRC-1:0]            s_afvalid_o,
    input  logic [NUM_SRC-1:0]            s_afready_i,
    output logic                          m_atvalid_o,
    output logic [ATID_WIDTH-1:0]         m_atid_o,
    output logic [DATA_WIDTH-1:0]         m_atdata_o,
    output logic                          m_atlast_o,
    input  logic                          m_atready_i,
    input  logic                          flush_req_i,
    output logic                          flush_done_o,
    output logic [$clog2(NUM_SRC)-1:0]    cur_src_o
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    // After reset the pointer sits on the last source, so src0 is searched first.
    localparam logic [SRC_W-1:0] c_PTR_RESET = SRC_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [SRC_W-1:0]        r_ptr;
    logic [SRC_W-1:0]        r_cur_src;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic [NUM_SRC-1:0]      r_pend;
    logic                    r_flush_done;
    logic                    r_m_atvalid;
    logic [ATID_WIDTH-1:0]   r_m_atid;
    logic [DATA_WIDTH-1:0]   r_m_atdata;
    logic                    r_m_atlast;

    // ------------------------------------------------------------------------
    // Split the packed per-source buses into arrays indexed by source number.
    // ------------------------------------------------------------------------
    logic [ATID_WIDTH-1:0] w_src_id   [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_id[gi]   = s_atid_i[gi*ATID_WIDTH +: ATID_WIDTH];
            assign w_src_data[gi] = s_atdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search. The search starts at ptr+1 and wraps. The pointer's
    // own source is checked last, so a source that is the only requester can
    // be granted again after it has been forcibly released at HOLD_MAX.
    // ------------------------------------------------------------------------
    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return SRC_W'(sum);
    endfunction

    logic [NUM_SRC-1:0] w_req;
    logic               w_found;
    logic [SRC_W-1:0]   w_winner;
    logic [SRC_W-1:0]   w_cand;

    assign w_req = s_atvalid_i & cfg_enable_i;

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_cand = rr_index(r_ptr, i);
            if (!w_found && w_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake with the granted source. The output slot is free when it is
    // empty or is draining this cycle. This gives one beat per cycle within a
    // grant. If the grant's enable drops, ready is withheld immediately.
    // ------------------------------------------------------------------------
    logic               w_slot_free;
    logic               w_grant_live;
    logic               w_accept;
    logic               w_release;
    logic [NUM_SRC-1:0] w_ready;

    assign w_slot_free  = !r_m_atvalid || m_atready_i;
    assign w_grant_live = (r_state == ST_BURST) && cfg_enable_i[r_cur_src];
    assign w_accept     = w_grant_live && w_slot_free && s_atvalid_i[r_cur_src];
    assign w_release    = w_accept && (s_atlast_i[r_cur_src] || (r_beat_cnt == c_CNT_LAST));

    always_comb begin
        w_ready = '0;
        if (w_grant_live && w_slot_free) begin
            w_ready[r_cur_src] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control state machine and output slice
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_ptr        <= c_PTR_RESET;
            r_cur_src    <= '0;
            r_beat_cnt   <= '0;
            r_pend       <= '0;
            r_flush_done <= 1'b0;
            r_m_atvalid  <= 1'b0;
            r_m_atid     <= '0;
            r_m_atdata   <= '0;
            r_m_atlast   <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;

            // The output slice keeps draining in every state, including FLUSH.
            if (w_accept) begin
                r_m_atvalid <= 1'b1;
                r_m_atid    <= w_src_id[r_cur_src];
                r_m_atdata  <= w_src_data[r_cur_src];
                r_m_atlast  <= s_atlast_i[r_cur_src];
            end else if (m_atready_i) begin
                r_m_atvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // A flush request has priority over a new data grant.
                    if (flush_req_i) begin
                        r_state <= ST_FLUSH;
                        r_pend  <= cfg_enable_i;
                    end else if (w_found) begin
                        r_state    <= ST_BURST;
                        r_cur_src  <= w_winner;
                        r_ptr      <= w_winner;
                        r_beat_cnt <= '0;
                    end
                end

                ST_BURST: begin
                    // ATID labels every beat, so the grant can be released
                    // mid-packet without corrupting the trace stream.
                    if (!cfg_enable_i[r_cur_src]) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_release) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_FLUSH: begin
                    r_pend <= r_pend & ~s_afready_i;
                    // Done only after every source has acknowledged and the
                    // last buffered beat has left the output register.
                    if ((r_pend == '0) && !r_m_atvalid) begin
                        r_flush_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_atready_o  = w_ready;
    assign s_afvalid_o  = r_pend;
    assign m_atvalid_o  = r_m_atvalid;
    assign m_atid_o     = r_m_atid;
    assign m_atdata_o   = r_m_atdata;
    assign m_atlast_o   = r_m_atlast;
    assign flush_done_o = r_flush_done;
    assign cur_src_o    = r_cur_src;

endmodule
`default_nettype wire

// File: tb/tb_atb_funnel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atb_funnel_arbiter
//  Purpose  : Directed self-checking bench for atb_funnel_arbiter.
//             Each source emits a beat stream with data = {src, running seq}
//             and ATID = 0x10 + src. Output beats are logged, then compared
//             against hand-derived expected sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atb_funnel_arbiter;

    localparam int NUM_SRC  = 4;
    localparam int DW       = 64;
    localparam int IW       = 7;
    localparam int HOLD_MAX = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NUM_SRC-1:0]    cfg_enable_i;
    logic [NUM_SRC-1:0]    s_atvalid_i;
    logic [NUM_SRC*IW-1:0] s_atid_i;
    logic [NUM_SRC*DW-1:0] s_atdata_i;
    logic [NUM_SRC-1:0]    s_atlast_i;
    logic [NUM_SRC-1:0]    s_atready_o;
    logic [NUM_SRC-1:0]    s_afvalid_o;
    logic [NUM_SRC-1:0]    s_afready_i;
    logic                  m_atvalid_o;
    logic [IW-1:0]         m_atid_o;
    logic [DW-1:0]         m_atdata_o;
    logic                  m_atlast_o;
    logic                  m_atready_i;
    logic                  flush_req_i;
    logic                  flush_done_o;
    logic [1:0]            cur_src_o;

    atb_funnel_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DW),
        .ATID_WIDTH (IW),
        .HOLD_MAX   (HOLD_MAX)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_enable_i (cfg_enable_i),
        .s_atvalid_i  (s_atvalid_i),
        .s_atid_i     (s_atid_i),
        .s_atdata_i   (s_atdata_i),
        .s_atlast_i   (s_atlast_i),
        .s_atready_o  (s_atready_o),
        .s_afvalid_o  (s_afvalid_o),
        .s_afready_i  (s_afready_i),
        .m_atvalid_o  (m_atvalid_o),
        .m_atid_o     (m_atid_o),
        .m_atdata_o   (m_atdata_o),
        .m_atlast_o   (m_atlast_o),
        .m_atready_i  (m_atready_i),
        .flush_req_i  (flush_req_i),
        .flush_done_o (flush_done_o),
        .cur_src_o    (cur_src_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source stream state: packets left, packet length, position, running seq
    int pkts [NUM_SRC];
    int plen [NUM_SRC];
    int pos  [NUM_SRC];
    int seq  [NUM_SRC];

    logic [DW-1:0] rec_data [$];
    logic [IW-1:0] rec_id   [$];
    logic          rec_last [$];
    int            rec_cyc  [$];

    function automatic void model_clear();
        for (int s = 0; s < NUM_SRC; s++) begin
            pkts[s] = 0;
            plen[s] = 1;
            pos[s]  = 0;
            seq[s]  = 0;
        end
        rec_data.delete();
        rec_id.delete();
        rec_last.delete();
        rec_cyc.delete();
    endfunction

    function automatic void drive_sources();
        for (int s = 0; s < NUM_SRC; s++) begin
            s_atvalid_i[s]         = (pkts[s] > 0);
            s_atid_i[s*IW +: IW]   = 7'(16 + s);
            s_atdata_i[s*DW +: DW] = {8'(s), 56'(seq[s])};
            s_atlast_i[s]          = (pos[s] == plen[s] - 1);
        end
    endfunction

    // One clock: sample the handshakes at the falling edge, then advance the
    // source streams just after the rising edge.
    task automatic tick();
        logic [NUM_SRC-1:0] acc;
        @(negedge clk_i);
        acc = s_atvalid_i & s_atready_o;
        if (m_atvalid_o && m_atready_i) begin
            rec_data.push_back(m_atdata_o);
            rec_id.push_back(m_atid_o);
            rec_last.push_back(m_atlast_o);
            rec_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (acc[s]) begin
                seq[s]++;
                pos[s]++;
                if (pos[s] == plen[s]) begin
                    pos[s] = 0;
                    pkts[s]--;
                end
            end
        end
        drive_sources();
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        cfg_enable_i = 4'b1111;
        s_afready_i  = '0;
        m_atready_i  = 1'b1;
        flush_req_i  = 1'b0;
        model_clear();
        drive_sources();
        #3;
        checks++;
        if ({m_atvalid_o, m_atlast_o, flush_done_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {m_atvalid_o, m_atlast_o, flush_done_o});
        end
        checks++;
        if ({s_atready_o, s_afvalid_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ready_afvalid: got %h expected 00", {s_atready_o, s_afvalid_o});
        end
        checks++;
        if (cur_src_o !== 2'd0 || m_atdata_o !== 64'd0 || m_atid_o !== 7'd0) begin
            errors++;
            $display("FAIL reset_regs: got cur=%0d data=%h id=%h expected zeros", cur_src_o, m_atdata_o, m_atid_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_round_robin();
        int exp_src [16] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3};
        int exp_seq [16] = '{0,1,0,1,0,1,0,1,2,3,2,3,2,3,2,3};
        int c0;
        logic [DW-1:0] d;
        model_clear();
        for (int s = 0; s < NUM_SRC; s++) begin
            pkts[s] = 2;
            plen[s] = 2;
        end
        cfg_enable_i = 4'b1111;
        m_atready_i  = 1'b1;
        drive_sources();
        c0 = cyc;
        repeat (32) tick();
        checks++;
        if (rec_data.size() != 16) begin
            errors++;
            $display("FAIL rr_count: got %0d beats expected 16", rec_data.size());
        end
        for (int i = 0; i < 16 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'(exp_src[i]), 56'(exp_seq[i])} || rec_id[i] !== 7'(16 + exp_src[i])
                || rec_last[i] !== ((exp_seq[i] % 2) == 1)) begin
                errors++;
                $display("FAIL rr_beat[%0d]: got data=%h id=%h last=%b expected src=%0d seq=%0d",
                         i, d, rec_id[i], rec_last[i], exp_src[i], exp_seq[i]);
            end
        end
        if (rec_cyc.size() == 16) begin
            checks++;
            if (rec_cyc[0] - c0 != 2) begin
                errors++;
                $display("FAIL rr_latency: got %0d expected 2", rec_cyc[0] - c0);
            end
            checks++;
            if (rec_cyc[1] - rec_cyc[0] != 1 || rec_cyc[2] - rec_cyc[1] != 2) begin
                errors++;
                $display("FAIL rr_bubble: got %0d,%0d expected 1,2", rec_cyc[1] - rec_cyc[0], rec_cyc[2] - rec_cyc[1]);
            end
            checks++;
            if (rec_cyc[15] - rec_cyc[0] != 22) begin
                errors++;
                $display("FAIL rr_span: got %0d expected 22", rec_cyc[15] - rec_cyc[0]);
            end
        end
    endtask

    task automatic test_hold_max();
        int exp_src [22] = '{1,1,1,1,1,1,1,1,2,2,1,1,1,1,1,1,1,1,1,1,1,1};
        int exp_seq [22] = '{0,1,2,3,4,5,6,7,0,1,8,9,10,11,12,13,14,15,16,17,18,19};
        logic [DW-1:0] d;
        model_clear();
        pkts[1] = 1; plen[1] = 20;
        pkts[2] = 1; plen[2] = 2;
        drive_sources();
        repeat (40) tick();
        checks++;
        if (rec_data.size() != 22) begin
            errors++;
            $display("FAIL hold_count: got %0d beats expected 22", rec_data.size());
        end
        for (int i = 0; i < 22 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'(exp_src[i]), 56'(exp_seq[i])} || rec_last[i] !== (i == 9 || i == 21)) begin
                errors++;
                $display("FAIL hold_beat[%0d]: got data=%h last=%b expected src=%0d seq=%0d",
                         i, d, rec_last[i], exp_src[i], exp_seq[i]);
            end
        end
        if (rec_cyc.size() == 22) begin
            checks++;
            if (rec_cyc[7] - rec_cyc[0] != 7 || rec_cyc[8] - rec_cyc[7] != 2 || rec_cyc[18] - rec_cyc[17] != 2) begin
                errors++;
                $display("FAIL hold_timing: got %0d,%0d,%0d expected 7,2,2",
                         rec_cyc[7] - rec_cyc[0], rec_cyc[8] - rec_cyc[7], rec_cyc[18] - rec_cyc[17]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        logic [DW-1:0] d;
        model_clear();
        pkts[0] = 1; plen[0] = 6;
        m_atready_i = 1'b1;
        drive_sources();
        repeat (3) tick();
        m_atready_i = 1'b0;
        held = m_atdata_o;
        checks++;
        if (held !== {8'd0, 56'd1} || m_atvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_start: got valid=%b data=%h expected 1 %h", m_atvalid_o, held, {8'd0, 56'd1});
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (m_atvalid_o !== 1'b1 || m_atdata_o !== held || m_atid_o !== 7'h10 || s_atready_o !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got valid=%b data=%h id=%h ready=%b expected 1 %h 10 0000",
                         k, m_atvalid_o, m_atdata_o, m_atid_o, s_atready_o, held);
            end
        end
        checks++;
        if (seq[0] != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d expected 2", seq[0]);
        end
        m_atready_i = 1'b1;
        repeat (12) tick();
        checks++;
        if (rec_data.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d beats expected 6", rec_data.size());
        end
        for (int i = 0; i < 6 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'd0, 56'(i)} || rec_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got data=%h last=%b expected seq %0d", i, d, rec_last[i], i);
            end
        end
    endtask

    task automatic test_enable_mask();
        int exp_a_src [6]  = '{1,1,3,3,0,0};
        int exp_b_src [12] = '{0,0,1,1,0,0,0,0,0,0,0,0};
        int exp_b_seq [12] = '{0,1,0,1,2,3,4,5,6,7,8,9};
        logic [DW-1:0] d;
        // Part A: src2 masked while every source requests
        model_clear();
        for (int s = 0; s < NUM_SRC; s++) begin
            pkts[s] = 1;
            plen[s] = 2;
        end
        cfg_enable_i = 4'b1011;
        drive_sources();
        repeat (25) tick();
        checks++;
        if (rec_data.size() != 6 || pkts[2] != 1) begin
            errors++;
            $display("FAIL en_count: got %0d beats pkts2=%0d expected 6 1", rec_data.size(), pkts[2]);
        end
        for (int i = 0; i < 6 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'(exp_a_src[i]), 56'(i % 2)}) begin
                errors++;
                $display("FAIL en_beat[%0d]: got %h expected src=%0d seq=%0d", i, d, exp_a_src[i], i % 2);
            end
        end
        // Part B: enable of the granted source drops mid-burst
        model_clear();
        pkts[0] = 1; plen[0] = 10;
        drive_sources();
        repeat (3) tick();
        cfg_enable_i = 4'b1010;
        #1;
        checks++;
        if (s_atready_o !== 4'b0000 || cur_src_o !== 2'd0) begin
            errors++;
            $display("FAIL en_drop_ready: got ready=%b cur=%0d expected 0000 0", s_atready_o, cur_src_o);
        end
        tick();
        cfg_enable_i = 4'b1011;
        pkts[1] = 1; plen[1] = 2;
        drive_sources();
        #1;
        checks++;
        if (s_atready_o !== 4'b0000) begin
            errors++;
            $display("FAIL en_released: got ready=%b expected 0000", s_atready_o);
        end
        repeat (30) tick();
        checks++;
        if (rec_data.size() != 12) begin
            errors++;
            $display("FAIL en_drop_count: got %0d beats expected 12", rec_data.size());
        end
        for (int i = 0; i < 12 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'(exp_b_src[i]), 56'(exp_b_seq[i])} || rec_last[i] !== (i == 3 || i == 11)) begin
                errors++;
                $display("FAIL en_drop_beat[%0d]: got data=%h last=%b expected src=%0d seq=%0d",
                         i, d, rec_last[i], exp_b_src[i], exp_b_seq[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [NUM_SRC-1:0] exp_af;
        int pulses;
        logic [DW-1:0] d;
        // Part A: two sources acknowledge at different times, src1 also has data waiting
        model_clear();
        cfg_enable_i = 4'b0110;
        pkts[1] = 1; plen[1] = 2;
        flush_req_i = 1'b1;
        drive_sources();
        tick();
        flush_req_i = 1'b0;
        pulses = 0;
        for (int c = 0; c <= 12; c++) begin
            s_afready_i    = '0;
            s_afready_i[1] = (c == 3);
            s_afready_i[2] = (c == 7);
            exp_af = (c <= 3) ? 4'b0110 : ((c <= 7) ? 4'b0100 : 4'b0000);
            checks++;
            if (s_afvalid_o !== exp_af) begin
                errors++;
                $display("FAIL fl_afvalid[%0d]: got %b expected %b", c, s_afvalid_o, exp_af);
            end
            checks++;
            if (flush_done_o !== (c == 9)) begin
                errors++;
                $display("FAIL fl_done[%0d]: got %b expected %b", c, flush_done_o, (c == 9));
            end
            if (flush_done_o === 1'b1) pulses++;
            if (c <= 9) begin
                checks++;
                if (s_atready_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL fl_no_grant[%0d]: got ready=%b expected 0000", c, s_atready_o);
                end
            end
            tick();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL fl_pulses: got %0d expected 1", pulses);
        end
        repeat (8) tick();
        checks++;
        if (rec_data.size() != 2) begin
            errors++;
            $display("FAIL fl_after_data: got %0d beats expected 2", rec_data.size());
        end else begin
            d = rec_data[1];
            checks++;
            if (d !== {8'd1, 56'd1}) begin
                errors++;
                $display("FAIL fl_after_beat: got %h expected %h", d, {8'd1, 56'd1});
            end
        end
        // Part B: nothing pending, but a beat is stuck in the output register
        model_clear();
        cfg_enable_i = 4'b1011;
        pkts[3] = 1; plen[3] = 1;
        m_atready_i = 1'b0;
        drive_sources();
        repeat (2) tick();
        flush_req_i  = 1'b1;
        cfg_enable_i = 4'b0000;
        tick();
        flush_req_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (flush_done_o !== 1'b0 || m_atvalid_o !== 1'b1 || s_afvalid_o !== 4'b0000) begin
                errors++;
                $display("FAIL fl_wait_drain[%0d]: got done=%b valid=%b af=%b expected 0 1 0000",
                         k, flush_done_o, m_atvalid_o, s_afvalid_o);
            end
            tick();
        end
        m_atready_i = 1'b1;
        tick();
        checks++;
        if (flush_done_o !== 1'b0 || m_atvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_drained: got done=%b valid=%b expected 0 0", flush_done_o, m_atvalid_o);
        end
        tick();
        checks++;
        if (flush_done_o !== 1'b1) begin
            errors++;
            $display("FAIL fl_done_after_drain: got %b expected 1", flush_done_o);
        end
        tick();
        checks++;
        if (flush_done_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_done_single: got %b expected 0", flush_done_o);
        end
        checks++;
        if (rec_data.size() != 1 || rec_last.size() != 1) begin
            errors++;
            $display("FAIL fl_stuck_beat_count: got %0d expected 1", rec_data.size());
        end else begin
            d = rec_data[0];
            checks++;
            if (d !== {8'd3, 56'd0} || rec_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL fl_stuck_beat: got %h last=%b expected %h 1", d, rec_last[0], {8'd3, 56'd0});
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] d;
        model_clear();
        cfg_enable_i = 4'b1111;
        pkts[2] = 1; plen[2] = 10;
        m_atready_i = 1'b0;
        drive_sources();
        repeat (2) tick();
        checks++;
        if (cur_src_o !== 2'd2 || m_atvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got cur=%0d valid=%b expected 2 1", cur_src_o, m_atvalid_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({m_atvalid_o, m_atlast_o, flush_done_o} !== 3'b000 || m_atdata_o !== 64'd0 || m_atid_o !== 7'd0) begin
            errors++;
            $display("FAIL rst_async_out: got valid=%b last=%b done=%b data=%h id=%h expected zeros",
                     m_atvalid_o, m_atlast_o, flush_done_o, m_atdata_o, m_atid_o);
        end
        checks++;
        if (s_atready_o !== 4'b0000 || s_afvalid_o !== 4'b0000 || cur_src_o !== 2'd0) begin
            errors++;
            $display("FAIL rst_async_ctl: got ready=%b af=%b cur=%0d expected 0000 0000 0",
                     s_atready_o, s_afvalid_o, cur_src_o);
        end
        model_clear();
        drive_sources();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            pkts[s] = 1;
            plen[s] = 1;
        end
        m_atready_i = 1'b1;
        drive_sources();
        repeat (16) tick();
        checks++;
        if (rec_data.size() != 4) begin
            errors++;
            $display("FAIL rst_after_count: got %0d beats expected 4", rec_data.size());
        end
        for (int i = 0; i < 4 && i < rec_data.size(); i++) begin
            d = rec_data[i];
            checks++;
            if (d !== {8'(i), 56'd0}) begin
                errors++;
                $display("FAIL rst_after_beat[%0d]: got %h expected src=%0d seq=0", i, d, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_max();
        test_backpressure();
        test_enable_mask();
        test_flush();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
